// File: rtl/cbus_mem_responder.sv
// Cache-bus responder: serves WRAP burst reads/writes from a word-addressed array after a
// programmable first-beat latency. Define CBUS_RESP_RANDOM_STALL_EN to insert LFSR-driven stalls.
module cbus_mem_responder #(
  parameter int unsigned MEM_ADDR_BITS    = 12,
  parameter int unsigned READ_LATENCY     = 2,
  parameter int unsigned MAX_ORDER        = 4,
  parameter string       INIT_FILE        = "",
  parameter int unsigned CBUS_ADDR_WIDTH  = 32,
  parameter int unsigned CBUS_DATA_WIDTH  = 32,
  parameter int unsigned CBUS_ORDER_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cbus_req_valid,
  input  logic                        cbus_req_is_write,
  input  logic [CBUS_ADDR_WIDTH-1:0]  cbus_req_addr,
  input  logic [CBUS_ORDER_WIDTH-1:0] cbus_req_order,
  input  logic [CBUS_DATA_WIDTH-1:0]  cbus_req_wdata,
  output logic                        cbus_resp_okay,
  output logic                        cbus_resp_last,
  output logic [CBUS_DATA_WIDTH-1:0]  cbus_resp_rdata
);

  localparam int unsigned CBUS_DATA_ORDER = $clog2(CBUS_DATA_WIDTH / 8);
  localparam int unsigned Depth  = 2 ** MEM_ADDR_BITS;
  localparam int unsigned OrdCap = (MAX_ORDER < MEM_ADDR_BITS) ? MAX_ORDER : MEM_ADDR_BITS;
  localparam int unsigned CntW   = (OrdCap < 1) ? 1 : OrdCap;
  localparam int unsigned LatW   = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  logic [CBUS_DATA_WIDTH-1:0] mem [Depth];

  state_e                   state_q;
  logic [MEM_ADDR_BITS-1:0] beat_q;
  logic [MEM_ADDR_BITS-1:0] mask_q;
  logic [CntW-1:0]          cnt_q;
  logic [LatW-1:0]          lat_q;
  logic                     wr_q;

  logic [MEM_ADDR_BITS-1:0] req_idx;
  logic [MEM_ADDR_BITS-1:0] req_mask;
  logic [MEM_ADDR_BITS-1:0] beat_next;
  logic                     stall;
  logic                     beat_go;
  logic                     unused_addr;

  assign req_idx     = cbus_req_addr[CBUS_DATA_ORDER +: MEM_ADDR_BITS];
  assign unused_addr = ^cbus_req_addr;

  // The wrap mask (2**ord - 1) doubles as the beat counter load value.
  always_comb begin
    req_mask = '0;
    for (int i = 0; i < int'(MEM_ADDR_BITS); i++) begin
      if (i < int'(OrdCap) && i < int'(cbus_req_order)) req_mask[i] = 1'b1;
    end
  end

  assign beat_next = (beat_q & ~mask_q) | ((beat_q + MEM_ADDR_BITS'(1)) & mask_q);

`ifdef CBUS_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign beat_go = (state_q == StBurst) && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cbus_req_valid) begin
            beat_q  <= req_idx;
            mask_q  <= req_mask;
            cnt_q   <= req_mask[CntW-1:0];
            lat_q   <= LatW'(READ_LATENCY);
            wr_q    <= cbus_req_is_write;
            state_q <= (READ_LATENCY > 0) ? StWait : StBurst;
          end
        end
        StWait: begin
          lat_q <= lat_q - LatW'(1);
          if (lat_q == LatW'(1)) state_q <= StBurst;
        end
        StBurst: begin
          if (beat_go) begin
            beat_q <= beat_next;
            cnt_q  <= cnt_q - CntW'(1);
            if (cnt_q == '0) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array is never cleared by reset; a beat coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (beat_go && wr_q && !reset) mem[beat_q] <= cbus_req_wdata;
  end

  assign cbus_resp_okay  = beat_go;
  assign cbus_resp_last  = beat_go && (cnt_q == '0);
  assign cbus_resp_rdata = beat_go ? mem[beat_q] : '0;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Randomized self-checking bench for cbus_mem_responder against a queue-based burst model.
module tb_cbus_mem_responder;

  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 2;
  localparam int unsigned MAXO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, is_write;
  logic [31:0] addr;
  logic [3:0]  order;
  logic [31:0] wdata;
  logic        okay, last;
  logic [31:0] rdata;

  logic        r0_valid, r0_is_write;
  logic [31:0] r0_addr;
  logic [3:0]  r0_order;
  logic [31:0] r0_wdata;
  logic        r0_okay, r0_last;
  logic [31:0] r0_rdata;

  always #5 clk = ~clk;

  cbus_mem_responder #(
    .MEM_ADDR_BITS(AW), .READ_LATENCY(LAT), .MAX_ORDER(MAXO), .INIT_FILE(""),
    .CBUS_ADDR_WIDTH(32), .CBUS_DATA_WIDTH(32), .CBUS_ORDER_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cbus_req_valid(valid), .cbus_req_is_write(is_write), .cbus_req_addr(addr),
    .cbus_req_order(order), .cbus_req_wdata(wdata),
    .cbus_resp_okay(okay), .cbus_resp_last(last), .cbus_resp_rdata(rdata)
  );

  cbus_mem_responder #(
    .MEM_ADDR_BITS(AW), .READ_LATENCY(0), .MAX_ORDER(MAXO), .INIT_FILE(""),
    .CBUS_ADDR_WIDTH(32), .CBUS_DATA_WIDTH(32), .CBUS_ORDER_WIDTH(4)
  ) dut0 (
    .clk(clk), .reset(reset),
    .cbus_req_valid(r0_valid), .cbus_req_is_write(r0_is_write), .cbus_req_addr(r0_addr),
    .cbus_req_order(r0_order), .cbus_req_wdata(r0_wdata),
    .cbus_resp_okay(r0_okay), .cbus_resp_last(r0_last), .cbus_resp_rdata(r0_rdata)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: memory image with a per-word "value is known" flag.
  logic [31:0] mm [4096];
  bit          known [4096];

  typedef struct {
    int unsigned word;
    bit          kn;
    logic [31:0] rd;
    bit          lst;
    bit          wr;
    logic [31:0] wd;
    int unsigned cyc;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] wb [16];
  int unsigned plan_words [16];

  function automatic int unsigned eff_ord(input int unsigned o);
    int unsigned r;
    r = o;
    if (r > MAXO) r = MAXO;
    if (r > AW) r = AW;
    return r;
  endfunction

  task automatic plan(input bit wr, input logic [31:0] a, input int unsigned o,
                      input int unsigned c_acc);
    int unsigned n, base, w;
    beat_t b;
    n    = 1 << eff_ord(o);
    base = (a >> 2) & 32'hFFF;
    for (int i = 0; i < int'(n); i++) begin
      w = (base & ~(n - 1)) | ((base + i) & (n - 1));
      plan_words[i] = w;
      b.word = w;
      b.kn   = known[w];
      b.rd   = mm[w];
      b.lst  = (i == int'(n) - 1);
      b.wr   = wr;
      b.wd   = wb[i];
      b.cyc  = c_acc + LAT + i;
      exp_q.push_back(b);
    end
  endtask

  // Compare process: every cycle, outputs must match the head of the expected beat queue.
  always @(negedge clk) begin
    beat_t e;
    if (okay) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_okay: got okay=1, required okay=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kn) chk("beat_rdata", rdata, e.rd);
        chk("beat_last", 32'(last), 32'(e.lst));
`ifndef CBUS_RESP_RANDOM_STALL_EN
        chk("beat_cycle", cyc, e.cyc);
`else
        if (cyc < e.cyc) chk("beat_too_early", cyc, e.cyc);
`endif
        if (e.wr && !reset) begin
          mm[e.word]    = e.wd;
          known[e.word] = 1'b1;
        end
      end
    end else begin
      chk("idle_last", 32'(last), 32'd0);
      chk("idle_rdata", rdata, 32'd0);
`ifndef CBUS_RESP_RANDOM_STALL_EN
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) chk("missing_okay", 32'(okay), 32'd1);
`endif
    end
  end

  logic [31:0] got [16];
  int          n_got;
  int unsigned present_cyc, first_cyc, last_cyc;

  // Issue one burst; if stop_at > 0, pulse reset during the stop_at-th okay cycle.
  task automatic burst(input bit wr, input logic [31:0] a, input int unsigned o,
                       input int stop_at);
    int  k, guard;
    bit  prev;
    @(posedge clk); #1;
    valid = 1'b1; is_write = wr; addr = a; order = o[3:0]; wdata = wb[0];
    present_cyc = cyc;
    plan(wr, a, o, cyc + 1);
    k = 0; prev = 1'b0; n_got = 0; guard = 0;
    forever begin
      @(posedge clk); #1;
      if (guard == 0) begin
        valid = 1'b0; is_write = 1'($urandom); addr = $urandom; order = 4'($urandom);
      end
      if (prev) k++;
      wdata = (k < 16) ? wb[k] : $urandom;
      prev = okay;
      if (okay) begin
        if (n_got == 0) first_cyc = cyc;
        if (n_got < 16) got[n_got] = rdata;
        n_got++;
        if (stop_at == n_got) begin
          reset = 1'b1;
          @(posedge clk); #1;
          chk("reset_okay", 32'(okay), 32'd0);
          chk("reset_last", 32'(last), 32'd0);
          reset = 1'b0;
          exp_q.delete();
          known[plan_words[stop_at-1]] = 1'b0;
          return;
        end
        if (last) begin
          last_cyc = cyc;
          return;
        end
      end
      guard++;
      if (guard > 400) begin
        chk("burst_timeout", 32'(n_got), 32'(exp_q.size()));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        return;
      end
    end
  endtask

  initial begin
    int unsigned prev_last;
    for (int i = 0; i < 4096; i++) known[i] = 1'b0;
    reset = 1'b1; valid = 1'b0; is_write = 1'b0; addr = '0; order = '0; wdata = '0;
    r0_valid = 1'b0; r0_is_write = 1'b0; r0_addr = '0; r0_order = '0; r0_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_okay", 32'(okay), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    reset = 1'b0;

    // Write then read back at 0x100.
    wb[0] = 32'h11; wb[1] = 32'h22; wb[2] = 32'h33; wb[3] = 32'h44;
    burst(1'b1, 32'h100, 2, 0);
    chk("wr_beats", 32'(n_got), 32'd4);
    burst(1'b0, 32'h100, 2, 0);
    chk("rd_beats", 32'(n_got), 32'd4);
    chk("rd_b0", got[0], 32'h11);
    chk("rd_b1", got[1], 32'h22);
    chk("rd_b2", got[2], 32'h33);
    chk("rd_b3", got[3], 32'h44);
`ifndef CBUS_RESP_RANDOM_STALL_EN
    chk("rd_latency", first_cyc - present_cyc, 32'd3);
`endif

    // Wrap read.
    for (int i = 0; i < 8; i++) wb[i] = i;
    burst(1'b1, 32'h100, 3, 0);
    burst(1'b0, 32'h114, 3, 0);
    chk("wrap_beats", 32'(n_got), 32'd8);
    for (int i = 0; i < 8; i++) chk("wrap_data", got[i], 32'((i + 5) % 8));
    prev_last = last_cyc;

    // Back-to-back read presented the cycle after last.
    burst(1'b0, 32'h108, 1, 0);
    chk("b2b_present", present_cyc, prev_last + 1);
    chk("b2b_d0", got[0], 32'd2);
    chk("b2b_d1", got[1], 32'd3);
`ifndef CBUS_RESP_RANDOM_STALL_EN
    chk("b2b_gap", first_cyc - prev_last - 1, 32'(1 + LAT));
`endif

    // Reset during the 3rd okay of a write burst.
    wb[0] = 32'hA1; wb[1] = 32'hB2; wb[2] = 32'hC3; wb[3] = 32'hD4;
    burst(1'b1, 32'h200, 2, 3);
    burst(1'b0, 32'h200, 2, 0);
    chk("rst_keep0", got[0], 32'hA1);
    chk("rst_keep1", got[1], 32'hB2);

`ifndef CBUS_RESP_RANDOM_STALL_EN
    // Single beat on the zero-latency instance.
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_is_write = 1'b1; r0_addr = 32'h10C; r0_order = 4'd0;
    r0_wdata = 32'hABCD1234;
    @(posedge clk); #1;
    r0_valid = 1'b0;
    chk("l0_wr_okay", 32'(r0_okay), 32'd1);
    chk("l0_wr_last", 32'(r0_last), 32'd1);
    @(posedge clk); #1;
    chk("l0_wr_done", 32'(r0_okay), 32'd0);
    r0_valid = 1'b1; r0_is_write = 1'b0;
    @(posedge clk); #1;
    r0_valid = 1'b0;
    chk("l0_rd_okay", 32'(r0_okay), 32'd1);
    chk("l0_rd_last", 32'(r0_last), 32'd1);
    chk("l0_rd_data", r0_rdata, 32'hABCD1234);
    @(posedge clk); #1;
    chk("l0_rd_done", 32'(r0_okay), 32'd0);
`endif

    // Randomized bursts with aliasing upper address bits and oversized orders.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      for (int i = 0; i < 16; i++) wb[i] = $urandom;
      a = ($urandom & 32'hFFFF_C000) | ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
      burst(1'($urandom), a, $urandom_range(0, 5), 0);
    end

    repeat (4) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
